// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Exports: state_t (RUN, DWAIT, HALTED), REG_W, REG_ZERO.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use detector: a load in ID/EX whose destination feeds the decode stage.
// Ports: ex_dren, ex_wsel, id_rs, id_rt in; lduse out (combinational).
module hazard_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic             ex_dren,
   input  logic [REG_W-1:0] ex_wsel,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             lduse
);

   // r0 is hardwired to zero, so a load into it can never be a real dependency
   assign lduse = ex_dren
                & (ex_wsel != REG_ZERO)
                & ((ex_wsel == id_rs) | (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: latch enables/flushes, PC enable, halt.
// Ports: CLK, nRST, ihit, dhit, mem_*, ex_*, id_rs/rt in; pc_en, *_en, *_flush, dwait, halt, stall_count out.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dren,
   input  logic             mem_dwen,
   input  logic             mem_pcsrc,
   input  logic             mem_halt,
   input  logic             ex_dren,
   input  logic [REG_W-1:0] ex_wsel,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             dwait,
   output logic             halt,
   output logic [CNT_W-1:0] stall_count
);

   state_t     state, next_state;
   logic       lduse;
   logic       dstall;
   logic       pc_c;
   logic [3:0] en_c;  // {ifid, idex, exmem, memwb}
   logic [3:0] fl_c;  // {ifid, idex, exmem, memwb}
   logic       stall_c;

   hazard_unit u_hazard (
      .ex_dren (ex_dren),
      .ex_wsel (ex_wsel),
      .id_rs   (id_rs),
      .id_rt   (id_rt),
      .lduse   (lduse)
   );

   assign dstall = (mem_dren | mem_dwen) & ~dhit;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // First matching rule wins; halt is checked ahead of the memory wait
   // so a halt paired with a pending access does not wait for dhit.
   always_comb begin
      next_state = state;
      pc_c       = 1'b0;
      en_c       = 4'b0000;
      fl_c       = 4'b0000;
      stall_c    = 1'b0;
      case (state)
         HALTED: begin
            next_state = HALTED;
         end
         default: begin
            next_state = RUN;
            if (mem_halt) begin
               en_c       = 4'b0001;
               fl_c       = 4'b1110;
               next_state = HALTED;
            end else if (dstall) begin
               stall_c    = 1'b1;
               next_state = DWAIT;
            end else if (mem_pcsrc) begin
               pc_c = 1'b1;
               en_c = 4'b1111;
               fl_c = 4'b1110;
            end else if (lduse) begin
               en_c    = 4'b0011;
               fl_c    = 4'b0100;
               stall_c = 1'b1;
            end else if (!ihit) begin
               en_c    = 4'b0111;
               fl_c    = 4'b1000;
               stall_c = 1'b1;
            end else begin
               pc_c = 1'b1;
               en_c = 4'b1111;
            end
         end
      endcase
   end

   assign pc_en       = pc_c    & nRST;
   assign ifid_en     = en_c[3] & nRST;
   assign idex_en     = en_c[2] & nRST;
   assign exmem_en    = en_c[1] & nRST;
   assign memwb_en    = en_c[0] & nRST;
   assign ifid_flush  = fl_c[3] & nRST;
   assign idex_flush  = fl_c[2] & nRST;
   assign exmem_flush = fl_c[1] & nRST;
   assign memwb_flush = fl_c[0] & nRST;

   assign dwait = (state == DWAIT);
   assign halt  = (state == HALTED);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_count <= '0;
      end else if (stall_c && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Vector table for single-cycle rules plus sequences for stall, halt, reset, saturation.
module tb_pipeline_ctrl;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       ihit, dhit, mem_dren, mem_dwen, mem_pcsrc, mem_halt, ex_dren;
   logic [4:0] ex_wsel, id_rs, id_rt;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic       dwait, halt;
   logic [31:0] stall_count;

   logic       s_pc, s_ife, s_ide, s_exe, s_mwe, s_iff, s_idf, s_exf, s_mwf;
   logic       s_dwait, s_halt;
   logic [3:0] s_count;

   int pass_n = 0;
   int total_n = 0;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .mem_pcsrc(mem_pcsrc), .mem_halt(mem_halt),
      .ex_dren(ex_dren), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .dwait(dwait), .halt(halt), .stall_count(stall_count)
   );

   pipeline_ctrl #(.CNT_W(4)) dut4 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .mem_pcsrc(mem_pcsrc), .mem_halt(mem_halt),
      .ex_dren(ex_dren), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
      .pc_en(s_pc), .ifid_en(s_ife), .idex_en(s_ide),
      .exmem_en(s_exe), .memwb_en(s_mwe),
      .ifid_flush(s_iff), .idex_flush(s_idf),
      .exmem_flush(s_exf), .memwb_flush(s_mwf),
      .dwait(s_dwait), .halt(s_halt), .stall_count(s_count)
   );

   // {pc_en, ifid/idex/exmem/memwb_en, ifid/idex/exmem/memwb_flush}
   localparam logic [8:0] O_RUN   = 9'b1_1111_0000;
   localparam logic [8:0] O_ZERO  = 9'b0_0000_0000;
   localparam logic [8:0] O_IMISS = 9'b0_0111_1000;
   localparam logic [8:0] O_LDUSE = 9'b0_0011_0100;
   localparam logic [8:0] O_BR    = 9'b1_1111_1110;
   localparam logic [8:0] O_HALT  = 9'b0_0001_1110;

   typedef struct {
      logic       ihit, dhit, dren, dwen, pcsrc, mhalt, exdren;
      logic [4:0] wsel, rs, rt;
      logic [8:0] exp_out;
      logic [31:0] exp_cnt;
      logic       exp_dwait, exp_halt;
   } vec_t;

   vec_t tbl [13];

   function automatic logic [8:0] outs();
      return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush};
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total_n++;
      if (got === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic idle();
      ihit = 1; dhit = 0; mem_dren = 0; mem_dwen = 0;
      mem_pcsrc = 0; mem_halt = 0; ex_dren = 0;
      ex_wsel = 0; id_rs = 0; id_rt = 0;
   endtask

   // Holds reset across one edge, checks the forced-zero outputs,
   // and releases it on a falling edge so the next cycle starts clean.
   task automatic do_reset();
      idle();
      nRST = 0;
      @(posedge CLK); #1;
      chk("rst_outs", {23'd0, outs()}, {23'd0, O_ZERO});
      chk("rst_state", {30'd0, dwait, halt}, 32'd0);
      chk("rst_cnt", stall_count, 32'd0);
      @(negedge CLK);
      nRST = 1;
   endtask

   initial begin
      tbl[0]  = '{1,0,0,0,0,0,0, 5'd0,5'd0,5'd0, O_RUN,   0, 0, 0};
      tbl[1]  = '{0,0,0,0,0,0,0, 5'd0,5'd0,5'd0, O_IMISS, 1, 0, 0};
      tbl[2]  = '{1,0,0,0,0,0,1, 5'd5,5'd0,5'd5, O_LDUSE, 1, 0, 0};
      tbl[3]  = '{1,0,0,0,0,0,1, 5'd7,5'd7,5'd3, O_LDUSE, 1, 0, 0};
      tbl[4]  = '{1,0,0,0,0,0,1, 5'd0,5'd0,5'd0, O_RUN,   0, 0, 0};
      tbl[5]  = '{1,0,0,0,0,0,0, 5'd5,5'd0,5'd5, O_RUN,   0, 0, 0};
      tbl[6]  = '{1,0,0,0,1,0,1, 5'd5,5'd0,5'd5, O_BR,    0, 0, 0};
      tbl[7]  = '{0,0,0,0,1,0,0, 5'd0,5'd0,5'd0, O_BR,    0, 0, 0};
      tbl[8]  = '{1,0,1,0,0,0,0, 5'd0,5'd0,5'd0, O_ZERO,  1, 1, 0};
      tbl[9]  = '{1,1,0,1,0,0,0, 5'd0,5'd0,5'd0, O_RUN,   0, 0, 0};
      tbl[10] = '{1,0,0,1,0,1,0, 5'd0,5'd0,5'd0, O_HALT,  0, 0, 1};
      tbl[11] = '{0,0,0,0,0,0,1, 5'd9,5'd9,5'd1, O_LDUSE, 1, 0, 0};
      tbl[12] = '{1,0,1,0,1,0,0, 5'd0,5'd0,5'd0, O_ZERO,  1, 1, 0};

      idle();
      for (int i = 0; i < 13; i++) begin
         do_reset();
         ihit = tbl[i].ihit; dhit = tbl[i].dhit;
         mem_dren = tbl[i].dren; mem_dwen = tbl[i].dwen;
         mem_pcsrc = tbl[i].pcsrc; mem_halt = tbl[i].mhalt;
         ex_dren = tbl[i].exdren; ex_wsel = tbl[i].wsel;
         id_rs = tbl[i].rs; id_rt = tbl[i].rt;
         #1;
         chk($sformatf("vec%0d_outs", i), {23'd0, outs()},
             {23'd0, tbl[i].exp_out});
         @(posedge CLK); #1;
         chk($sformatf("vec%0d_cnt", i), stall_count, tbl[i].exp_cnt);
         chk($sformatf("vec%0d_dwait", i), {31'd0, dwait},
             {31'd0, tbl[i].exp_dwait});
         chk($sformatf("vec%0d_halt", i), {31'd0, halt},
             {31'd0, tbl[i].exp_halt});
      end

      // Free-running, no hazards
      do_reset();
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("run_outs", {23'd0, outs()}, {23'd0, O_RUN});
         @(negedge CLK);
      end
      chk("run_cnt", stall_count, 32'd0);

      // Data wait: 3 stalled cycles, dhit in cycle 4
      do_reset();
      mem_dren = 1;
      for (int c = 1; c <= 4; c++) begin
         dhit = (c == 4);
         #1;
         chk($sformatf("dw%0d_outs", c), {23'd0, outs()},
             {23'd0, (c == 4) ? O_RUN : O_ZERO});
         chk($sformatf("dw%0d_dwait", c), {31'd0, dwait},
             {31'd0, (c >= 2)});
         @(negedge CLK);
      end
      mem_dren = 0; dhit = 0;
      #1;
      chk("dw_cnt", stall_count, 32'd3);
      chk("dw_exit", {31'd0, dwait}, 32'd0);

      // Asynchronous reset in the middle of a data wait
      mem_dwen = 1;
      @(negedge CLK); @(negedge CLK); #1;
      chk("dw2_dwait", {31'd0, dwait}, 32'd1);
      nRST = 0;
      #1;
      chk("arst_dwait", {31'd0, dwait}, 32'd0);
      chk("arst_cnt", stall_count, 32'd0);
      chk("arst_outs", {23'd0, outs()}, {23'd0, O_ZERO});
      @(negedge CLK);
      idle();
      nRST = 1;

      // Halt with a pending store: no wait for dhit
      do_reset();
      mem_halt = 1; mem_dwen = 1; dhit = 0;
      #1;
      chk("h_outs", {23'd0, outs()}, {23'd0, O_HALT});
      @(negedge CLK);
      idle();
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("h_hold_outs", {23'd0, outs()}, {23'd0, O_ZERO});
         chk("h_hold_halt", {31'd0, halt}, 32'd1);
         @(negedge CLK);
      end
      chk("h_cnt", stall_count, 32'd0);
      nRST = 0;
      #2;
      chk("h_rst_halt", {31'd0, halt}, 32'd0);
      nRST = 1;
      #1;
      chk("h_rst_outs", {23'd0, outs()}, {23'd0, O_RUN});
      @(negedge CLK);

      // Saturation of a 4-bit counter
      do_reset();
      ihit = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge CLK); #1;
         if (c == 10) chk("sat_mid", {28'd0, s_count}, 32'd10);
      end
      chk("sat_w4", {28'd0, s_count}, 32'd15);
      chk("sat_w32", stall_count, 32'd20);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
